// File: rtl/mold_msg_buf.sv
// mold_msg_buf: store-and-forward buffer behind the MoldUDP64 message
// extractor. Beats are written speculatively and become visible to the
// consumer only once the whole message has arrived. A message that does not
// fit in the committed free space is dropped whole. A start beat that
// arrives mid-message discards the partial message.
// Optional build macro: MOLD_MSG_BUF_STATS_EN adds the drop_cnt_o and
// trunc_cnt_o saturating counters.
module mold_msg_buf #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = 8,
  parameter int ML_W       = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  mold_msg_v_i,
  input  logic                  mold_msg_start_i,
  input  logic [ML_W-1:0]       mold_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
  output logic                  out_v_o,
  input  logic                  out_ready_i,
  output logic                  out_start_o,
  output logic                  out_last_o,
  output logic [ML_W-1:0]       out_len_o,
  output logic [AXI_KEEP_W-1:0] out_mask_o,
  output logic [AXI_DATA_W-1:0] out_data_o
`ifdef MOLD_MSG_BUF_STATS_EN
  ,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           trunc_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t DEPTH_V = ptr_t'(DEPTH);

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_KEEP_W-1:0] mask;
    logic                  start;
    logic                  last;
    logic [ML_W-1:0]       len;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    DROP
  } wr_state_t;

  entry_t          mem [DEPTH];
  wr_state_t       state_q, state_d;
  ptr_t            wr_q, wr_d;
  ptr_t            cm_q, cm_d;
  ptr_t            rd_q;
  logic [ML_W-1:0] rem_q, rem_d;

  logic            we;
  ptr_t            wr_addr;
  entry_t          w_entry;
  logic            drop_ev;
  logic            trunc_ev;

  // Beats covered by the incoming length; one extra bit keeps len + 7 exact.
  logic [ML_W:0]   beats;
  // Free space seen by the admission check; pops this cycle are not credited.
  ptr_t            free;
  logic            pop;

  assign beats = ({1'b0, mold_msg_len_i} + (ML_W+1)'(7)) >> 3;
  assign free  = DEPTH_V - (cm_q - rd_q);
  assign pop   = out_v_o & out_ready_i;

  // Write-side FSM: admission, speculative writes, commit, drop and truncation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    state_d        = state_q;
    wr_d           = wr_q;
    cm_d           = cm_q;
    rem_d          = rem_q;
    we             = 1'b0;
    wr_addr        = wr_q;
    w_entry.data   = mold_msg_data_i;
    w_entry.mask   = mold_msg_mask_i;
    w_entry.start  = 1'b0;
    w_entry.last   = 1'b0;
    w_entry.len    = mold_msg_len_i;
    drop_ev        = 1'b0;
    trunc_ev       = 1'b0;

    if (mold_msg_v_i && mold_msg_start_i) begin
      // A start beat mid-message rewinds to the last commit point first.
      if (state_q != IDLE) begin
        trunc_ev = 1'b1;
        wr_d     = cm_q;
        wr_addr  = cm_q;
        state_d  = IDLE;
      end
      if (mold_msg_len_i != '0) begin
        if (beats > (ML_W+1)'(free)) begin
          drop_ev = 1'b1;
          rem_d   = beats[ML_W-1:0] - ML_W'(1);
          state_d = (beats == (ML_W+1)'(1)) ? IDLE : DROP;
        end else begin
          we            = 1'b1;
          w_entry.start = 1'b1;
          w_entry.last  = (beats == (ML_W+1)'(1));
          wr_d          = wr_addr + PTR_ONE;
          if (beats == (ML_W+1)'(1)) begin
            cm_d    = wr_addr + PTR_ONE;
            state_d = IDLE;
          end else begin
            rem_d   = beats[ML_W-1:0] - ML_W'(1);
            state_d = WR;
          end
        end
      end
    end else if (mold_msg_v_i) begin
      unique case (state_q)
        WR: begin
          we           = 1'b1;
          w_entry.last = (rem_q == ML_W'(1));
          wr_d         = wr_q + PTR_ONE;
          rem_d        = rem_q - ML_W'(1);
          if (rem_q == ML_W'(1)) begin
            cm_d    = wr_q + PTR_ONE;
            state_d = IDLE;
          end
        end
        DROP: begin
          rem_d = rem_q - ML_W'(1);
          if (rem_q == ML_W'(1)) state_d = IDLE;
        end
        default: ;  // orphan beat in IDLE is ignored
      endcase
    end
  end

  // Pointer, FSM and remaining-beat registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      rem_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rem_q   <= rem_d;
      if (pop) rd_q <= rd_q + PTR_ONE;
    end
  end

  // Beat storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; pointers alone define which
    // entries are live, and leaving storage out of reset keeps it plain RAM.
    if (we) mem[wr_addr[PTR_W-1:0]] <= w_entry;
  end

  // Consumer side reads the head entry combinationally.
  always_comb begin
    out_v_o     = (rd_q != cm_q);
    out_data_o  = mem[rd_q[PTR_W-1:0]].data;
    out_mask_o  = mem[rd_q[PTR_W-1:0]].mask;
    out_start_o = mem[rd_q[PTR_W-1:0]].start;
    out_last_o  = mem[rd_q[PTR_W-1:0]].last;
    out_len_o   = mem[rd_q[PTR_W-1:0]].len;
  end

`ifdef MOLD_MSG_BUF_STATS_EN
  // Saturating counters of dropped and truncated messages.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      drop_cnt_o  <= '0;
      trunc_cnt_o <= '0;
    end else begin
      if (drop_ev && drop_cnt_o != 16'hFFFF)   drop_cnt_o  <= drop_cnt_o + 16'd1;
      if (trunc_ev && trunc_cnt_o != 16'hFFFF) trunc_cnt_o <= trunc_cnt_o + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = drop_ev ^ trunc_ev;
`endif

endmodule

// File: tb/tb_mold_msg_buf.sv
// Directed bench for mold_msg_buf with a scoreboard of expected output beats.
module tb_mold_msg_buf;

  logic        clk = 1'b0;
  logic        nreset;
  logic        v, start;
  logic [15:0] len_i;
  logic [7:0]  mask_i;
  logic [63:0] data_i;
  logic        out_v, out_ready, out_start, out_last;
  logic [15:0] out_len;
  logic [7:0]  out_mask;
  logic [63:0] out_data;
`ifdef MOLD_MSG_BUF_STATS_EN
  logic [15:0] drop_cnt, trunc_cnt;
`endif

  always #5 clk = ~clk;

  mold_msg_buf dut (
    .clk              (clk),
    .nreset           (nreset),
    .mold_msg_v_i     (v),
    .mold_msg_start_i (start),
    .mold_msg_len_i   (len_i),
    .mold_msg_mask_i  (mask_i),
    .mold_msg_data_i  (data_i),
    .out_v_o          (out_v),
    .out_ready_i      (out_ready),
    .out_start_o      (out_start),
    .out_last_o       (out_last),
    .out_len_o        (out_len),
    .out_mask_o       (out_mask),
    .out_data_o       (out_data)
`ifdef MOLD_MSG_BUF_STATS_EN
    ,
    .drop_cnt_o       (drop_cnt),
    .trunc_cnt_o      (trunc_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        start;
    logic        last;
    logic [15:0] len;
  } beat_t;

  beat_t sb[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_fail  = 0;
  int    msg_id  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic s, input logic [15:0] len, input logic [7:0] mask,
                      input logic [63:0] data);
    @(posedge clk); #1;
    v = 1'b1; start = s; len_i = len; mask_i = mask; data_i = data;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    v = 1'b0; start = 1'b0;
  endtask

  // Drives a message (nsend = 0 sends every beat); keep pushes it as expected output.
  task automatic send_msg(input logic [15:0] len, input int nsend, input bit keep);
    int    nb;
    int    bytes;
    beat_t b;
    nb = (int'(len) + 7) / 8;
    if (nsend != 0 && nsend < nb) nb = nsend;
    msg_id++;
    for (int i = 0; i < nb; i++) begin
      bytes   = int'(len) - 8 * i;
      b.mask  = (bytes >= 8) ? 8'hFF : 8'((1 << bytes) - 1);
      b.data  = {32'(msg_id), 32'(i) ^ 32'hA5A5_0000};
      b.start = (i == 0);
      b.last  = (i == (int'(len) + 7) / 8 - 1);
      b.len   = (i == 0) ? len : 16'h0;
      beat(b.start, len, b.mask, b.data);
      if (keep) sb.push_back(b);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_v) done = 1'b1;
    end
    check("drain_done", 128'(done), 128'd1);
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stalls hold.
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    beat_t cur, exp;
    cur = '{out_data, out_mask, out_start, out_last, out_len};
    if (!nreset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {out_v, cur}, {1'b1, held});
      if (out_v && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 128'(out_v), 128'd0);
        end else begin
          exp = sb.pop_front();
          cur.len = out_start ? out_len : 16'h0;
          check("out_beat", cur, exp);
        end
      end
      stalled = out_v && !out_ready;
      held    = cur;
      held.len = out_len;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nreset = 1'b0; v = 1'b0; start = 1'b0; len_i = '0; mask_i = '0; data_i = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_v", 128'(out_v), 128'd0);
`ifdef MOLD_MSG_BUF_STATS_EN
    check("reset_drop_cnt", 128'(drop_cnt), 128'd0);
`endif
    nreset = 1'b1;

    // Single 20-byte message; visible the cycle after its last beat.
    out_ready = 1'b1;
    send_msg(16'd20, 0, 1'b1);
    check("t1_uncommitted", 128'(out_v), 128'd0);
    idle();
    check("t1_commit_vis", 128'(out_v), 128'd1);
    drain();

    // Fill: 12 beats in, 5 dropped, 4 in (full), then a 1-beat message dropped.
    out_ready = 1'b0;
    send_msg(16'd96, 0, 1'b1);
    send_msg(16'd40, 0, 1'b0);
    send_msg(16'd32, 0, 1'b1);
    idle();
    check("t2_full_out_v", 128'(out_v), 128'd1);
`ifdef MOLD_MSG_BUF_STATS_EN
    check("t2_drop_cnt1", 128'(drop_cnt), 128'd1);
`endif
    send_msg(16'd8, 0, 1'b0);
    idle();
`ifdef MOLD_MSG_BUF_STATS_EN
    check("t2_drop_cnt2", 128'(drop_cnt), 128'd2);
`endif
    drain();

    // Oversized message never appears; the next one passes intact.
    send_msg(16'd200, 0, 1'b0);
    send_msg(16'd8, 0, 1'b1);
    idle();
    drain();

    // Truncation: a 24-byte message cut after one beat by an 8-byte message.
    send_msg(16'd24, 1, 1'b0);
    send_msg(16'd8, 0, 1'b1);
    idle();
`ifdef MOLD_MSG_BUF_STATS_EN
    check("t4_trunc_cnt", 128'(trunc_cnt), 128'd1);
`endif
    drain();

    // Back-to-back 1-beat messages with the consumer ready on alternate cycles.
    for (int i = 0; i < 20; i++) begin
      send_msg(16'd8, 0, 1'b1);
      out_ready = (i % 2 == 0);
    end
    idle();
    drain();

    // Reset during the second beat of a 3-beat message flushes everything.
    out_ready = 1'b0;
    send_msg(16'd8, 0, 1'b1);
    send_msg(16'd24, 2, 1'b0);
    nreset = 1'b0;
    @(posedge clk); #1;
    check("t6_reset_out_v", 128'(out_v), 128'd0);
`ifdef MOLD_MSG_BUF_STATS_EN
    check("t6_reset_trunc", 128'(trunc_cnt), 128'd0);
`endif
    sb.delete();
    v = 1'b0; start = 1'b0;
    nreset = 1'b1;
    out_ready = 1'b1;
    send_msg(16'd16, 0, 1'b1);
    idle();
    check("t6_after_reset_v", 128'(out_v), 128'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mold_msg_buf.md
# mold_msg_buf

Store-and-forward buffer that sits directly downstream of the MoldUDP64 message extractor. It accepts the extractor's 64-bit message beats, which arrive with no backpressure. Only complete messages are released to the consumer, on a valid/ready interface. Any message that cannot fit in the free space is dropped whole, so the consumer never sees a partial message.

## Interface
- `AXI_DATA_W`, 64: beat data width in bits.
- `AXI_KEEP_W`, 8: beat byte-mask width.
- `ML_W`, 16: message length field width, in bytes.
- `DEPTH`, 16: buffer capacity in beats; must be a power of 2, at least 2.
- `clk` input 1: clock.
- `nreset` input 1: reset, synchronous, active-low.
- `mold_msg_v_i` input 1: beat valid.
- `mold_msg_start_i` input 1: first beat of a message; qualified by `mold_msg_v_i`.
- `mold_msg_len_i` input ML_W: message length in bytes; sampled only on a start beat.
- `mold_msg_mask_i` input AXI_KEEP_W: valid-byte mask of the beat.
- `mold_msg_data_i` input AXI_DATA_W: beat data.
- `out_v_o` output 1: a committed beat is available.
- `out_ready_i` input 1: consumer accepts the beat.
- `out_start_o` output 1: first beat of a message.
- `out_last_o` output 1: last beat of a message.
- `out_len_o` output ML_W: message length; meaningful when `out_start_o` is high.
- `out_mask_o` output AXI_KEEP_W: byte mask.
- `out_data_o` output AXI_DATA_W: data.

## Operation
- Storage is a flop array of DEPTH entries. Each entry holds {data, mask, start, last, len}.
- Pointers are PTR_W+1 bits wide, where PTR_W = log2(DEPTH):
  - `wr_q`: speculative write pointer.
  - `cm_q`: committed write pointer.
  - `rd_q`: read pointer.
  - Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal. Pointers wrap naturally.
- beats = (len + 7) >> 3.
- free = DEPTH − (cm_q − rd_q), computed from registered values only. A pop in the same cycle is not credited.
- Write FSM states: IDLE, WR, DROP.
  - IDLE, start beat, len = 0: ignored; stay in IDLE.
  - IDLE, start beat, beats > free (this includes beats > DEPTH): go to DROP, load the remaining-beat count `rem_q` = beats − 1, nothing written. If `rem_q` = 0, stay in IDLE.
  - IDLE, start beat, otherwise: write the entry with start = 1 and last = (beats == 1), increment `wr_q`. If beats == 1, `cm_q` ← `wr_q` + 1 and stay in IDLE. Otherwise load `rem_q` = beats − 1 and go to WR.
  - IDLE, valid non-start beat: ignored (orphan).
  - WR, non-start beat: write with last = (`rem_q` == 1), increment `wr_q`, decrement `rem_q`. When last, `cm_q` ← `wr_q` + 1 and go to IDLE.
  - DROP, non-start beat: decrement `rem_q`; return to IDLE at 0.
  - WR or DROP, start beat (truncated message): `wr_q` ← `cm_q`, discarding the partial message. The new start beat is then handled exactly as in IDLE in the same cycle.
- Read side: `out_v_o` = (`rd_q` != `cm_q`).
  - Outputs are read combinationally from entry `rd_q`.
  - A pop happens when `out_v_o` & `out_ready_i`; `rd_q` increments.
- Simultaneous commit and pop are both applied.
- Reset values: `wr_q` = `cm_q` = `rd_q` = 0, FSM = IDLE, `rem_q` = 0.
  - `out_v_o` = 0. All other outputs are don't-care while `out_v_o` = 0.
  - Array contents are not reset.
- Reset mid-message discards everything, including committed beats.

## Timing
- Write: a beat present at edge N is stored at edge N.
- Commit: a last beat at edge N updates `cm_q` at edge N. `out_v_o` is high in cycle N+1 if the buffer was empty.
- Minimum latency from the last beat in to the first beat out is 1 cycle.
- The buffer must sustain one beat in and one beat out every cycle.
- `out_*` must hold stable while `out_v_o` & ~`out_ready_i`.

## Configuration
- `MOLD_MSG_BUF_STATS_EN` defined:
  - Adds output `drop_cnt_o` (16 bits) counting messages dropped for lack of space.
  - Adds output `trunc_cnt_o` (16 bits) counting truncated messages.
  - Both counters saturate at 0xFFFF and reset to 0.
- `MOLD_MSG_BUF_STATS_EN` undefined: the ports and counters do not exist. Datapath behaviour is identical.

## Test plan
- Single message, len = 20, `out_ready_i` = 1: 3 beats in (masks FF, FF, 0F) → 3 beats out starting 1 cycle after the last beat in. `out_start_o` on beat 0, `out_last_o` on beat 2, `out_len_o` = 20, `out_mask_o` = 0F on beat 2.
- DEPTH = 16, `out_ready_i` = 0:
  - Message of len 96 (12 beats) → accepted.
  - Then len 40 (5 beats) → dropped; `drop_cnt_o` = 1 with STATS_EN.
  - Then len 32 (4 beats) → accepted; the buffer is now full.
- Message with len 200 (25 beats > DEPTH) → never visible on the output; the next 8-byte message passes through intact.
- Start beat with len 24, then a new start with len 8 after 1 beat → only the 8-byte message is output; `trunc_cnt_o` = 1.
- Continuous back-to-back 1-beat messages with `out_ready_i` toggling 1,0,1,0 → no loss until full, in-order data, outputs stable while stalled.
- Assert `nreset` low during the second beat of a 3-beat message → `out_v_o` = 0 the cycle after reset. A subsequent message is output normally starting at entry 0.
